// File: rtl/simple_pkg.sv
// Shared phase codes, instruction class decode constants and ALU op-field
// thresholds used by the phase sequencer and its instruction classifier.
package simple_pkg;

  typedef enum logic [2:0] {
    PH_HALT = 3'd0,
    PH_IF   = 3'd1,
    PH_ID   = 3'd2,
    PH_EX   = 3'd3,
    PH_MEM  = 3'd4,
    PH_WB   = 3'd5
  } phase_t;

  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_ALU = 2'b11;

  localparam logic [4:0] CLS_LI = 5'b10000;
  localparam logic [4:0] CLS_B  = 5'b10100;
  localparam logic [4:0] CLS_BC = 5'b10111;

  localparam logic [3:0] ALU_FLAG_MAX = 4'b0110;
  localparam logic [3:0] ALU_REG_MAX  = 4'b1100;
  localparam logic [3:0] ALU_HLT_OP   = 4'b1111;

  typedef struct packed {
    logic ld;
    logic st;
    logic li;
    logic b;
    logic bc;
    logic alu;
    logic hlt;
    logic alu_flag;
    logic alu_reg;
  } instr_class_t;

  function automatic logic is_mem(input instr_class_t c);
    return c.ld | c.st;
  endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational instruction classifier: maps the instruction-register
// contents onto one-hot-ish class flags for the phase sequencer.
module instr_class
  import simple_pkg::*;
(
  input  logic [15:0]  command,
  output instr_class_t cls
);

  logic       alu;
  logic [3:0] op;
  logic       unused_bits;

  assign alu = (command[15:14] == CLS_ALU);
  assign op  = command[7:4];

  // Immediate/register fields do not influence sequencing.
  assign unused_bits = ^{command[10:8], command[3:0]};

  always_comb begin
    cls          = '0;
    cls.ld       = (command[15:14] == CLS_LD);
    cls.st       = (command[15:14] == CLS_ST);
    cls.li       = (command[15:11] == CLS_LI);
    cls.b        = (command[15:11] == CLS_B);
    cls.bc       = (command[15:11] == CLS_BC);
    cls.alu      = alu;
    cls.hlt      = alu && (op == ALU_HLT_OP);
    cls.alu_flag = alu && (op <= ALU_FLAG_MAX);
    cls.alu_reg  = alu && (op <= ALU_REG_MAX);
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer with retired-instruction counter.
// Define PHASE_SKIP_EN to let non-memory instructions bypass the MEM phase.
//
// state | meaning
// HALT  | idle, halted=1, waits for run
// IF    | instruction fetch, waits for mem_ack
// ID    | decode; HLT retires and stops here
// EX    | execute, ALU flag update
// MEM   | data access for LD/ST, idle cycle otherwise
// WB    | register write / branch, retires instruction
module phase_sequencer
  import simple_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] COMMAND,
  input  logic        mem_ack,
  input  logic        branch_taken,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        reg_we,
  output logic        flag_we,
  output logic        halted,
  output logic [2:0]  phase,
  output logic [15:0] retired
);

  phase_t       state, state_nxt;
  instr_class_t cls;
  logic         retire;
  logic [15:0]  retired_q;

  instr_class u_instr_class (
    .command (COMMAND),
    .cls     (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PH_HALT;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    state_nxt    = PH_HALT;
    retire       = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load_en   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    reg_we       = 1'b0;
    flag_we      = 1'b0;
    halted       = 1'b0;
    case (state)
      PH_HALT: begin
        halted    = 1'b1;
        state_nxt = run ? PH_IF : PH_HALT;
      end
      PH_IF: begin
        mem_req   = 1'b1;
        state_nxt = PH_IF;
        if (mem_ack) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = PH_ID;
        end
      end
      PH_ID: begin
        retire    = cls.hlt;
        state_nxt = cls.hlt ? PH_HALT : PH_EX;
      end
      PH_EX: begin
        flag_we = cls.alu_flag;
`ifdef PHASE_SKIP_EN
        state_nxt = is_mem(cls) ? PH_MEM : PH_WB;
`else
        state_nxt = PH_MEM;
`endif
      end
      PH_MEM: begin
        state_nxt = PH_WB;
        if (is_mem(cls)) begin
          mem_req      = 1'b1;
          mem_sel_data = 1'b1;
          mem_we       = cls.st;
          state_nxt    = mem_ack ? PH_WB : PH_MEM;
        end
      end
      PH_WB: begin
        reg_we     = cls.ld | cls.li | cls.alu_reg;
        pc_load_en = cls.b | (cls.bc & branch_taken);
        retire     = 1'b1;
        state_nxt  = PH_IF;
      end
      default: state_nxt = PH_HALT;
    endcase
  end

  assign phase   = state;
  assign retired = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer; expectations are
// hand-computed per instruction and compared phase by phase.
`timescale 1ns/1ps
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_ack, branch_taken;
  logic [15:0] COMMAND;
  logic        ir_load, pc_inc, pc_load_en, mem_req, mem_we, mem_sel_data;
  logic        reg_we, flag_we, halted;
  logic [2:0]  phase;
  logic [15:0] retired;
  logic [8:0]  strobes;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_retired;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .COMMAND      (COMMAND),
    .mem_ack      (mem_ack),
    .branch_taken (branch_taken),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_load_en   (pc_load_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel_data (mem_sel_data),
    .reg_we       (reg_we),
    .flag_we      (flag_we),
    .halted       (halted),
    .phase        (phase),
    .retired      (retired)
  );

  // ir_load pc_inc pc_load_en mem_req mem_we mem_sel_data reg_we flag_we halted
  assign strobes = {ir_load, pc_inc, pc_load_en, mem_req, mem_we, mem_sel_data,
                    reg_we, flag_we, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    @(negedge clk); run = 1'b1; #1;
    check("run in HALT", {29'd0, phase}, 32'd0);
  endtask

  // Entered with the DUT in IF; acks the fetch immediately.
  task automatic do_instr(input string tag, input logic [15:0] cmd, input int mem_wait,
                          input logic bt, input logic e_flag, input logic e_reg,
                          input logic e_pc);
    logic is_mem, is_st;
    is_mem = (cmd[15] == 1'b0);
    is_st  = (cmd[15:14] == 2'b01);

    @(negedge clk); run = 1'b0; COMMAND = cmd; branch_taken = bt; mem_ack = 1'b1; #1;
    check({tag, " IF"}, {phase, strobes, retired}, {3'd1, 9'b110100000, exp_retired});

    @(negedge clk); mem_ack = 1'b0; run = 1'b1; #1;
    check({tag, " ID"}, {phase, strobes}, {3'd2, 9'b0});

    @(negedge clk); run = 1'b0; #1;
    check({tag, " EX"}, {phase, strobes}, {3'd3, 7'b0, e_flag, 1'b0});

    if (is_mem) begin
      for (int i = 0; i <= mem_wait; i++) begin
        @(negedge clk); mem_ack = (i == mem_wait); #1;
        check({tag, " MEM"}, {phase, strobes}, {3'd4, 3'b000, 1'b1, is_st, 1'b1, 3'b000});
      end
    end else begin
`ifndef PHASE_SKIP_EN
      @(negedge clk); mem_ack = 1'b1; #1;
      check({tag, " MEM idle"}, {phase, strobes}, {3'd4, 9'b0});
`endif
    end

    @(negedge clk); mem_ack = 1'b0; #1;
    check({tag, " WB"}, {phase, strobes, retired},
          {3'd5, 2'b00, e_pc, 3'b000, e_reg, 2'b00, exp_retired});
    exp_retired = exp_retired + 16'd1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0;
    COMMAND = 16'h0000; exp_retired = 16'h0000;

    #12; run = 1'b1; mem_ack = 1'b1;
    #5;
    check("reset state", {phase, strobes, retired}, {3'd0, 9'b000000001, 16'h0000});

    @(negedge clk); reset = 1'b0; run = 1'b0; mem_ack = 1'b0; #1;
    check("post reset HALT", {phase, strobes}, {3'd0, 9'b000000001});
    @(negedge clk); #1;
    check("HALT holds", {phase, strobes}, {3'd0, 9'b000000001});

    start_run();
    do_instr("ADD",     16'hC000, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_instr("ST",      16'h4000, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr("LD",      16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr("BC tk",   16'hB800, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_instr("BC nt",   16'hB800, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr("B",       16'hA000, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_instr("ALU op6", 16'hC060, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_instr("ALU op7", 16'hC070, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr("ALU opC", 16'hC0C0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr("ALU opD", 16'hC0D0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr("NOP",     16'h8800, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr("LI",      16'h8000, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // HLT retires in ID and parks in HALT until run.
    @(negedge clk); COMMAND = 16'hC0F0; mem_ack = 1'b1; #1;
    check("HLT IF", {phase, strobes, retired}, {3'd1, 9'b110100000, exp_retired});
    @(negedge clk); mem_ack = 1'b0; #1;
    check("HLT ID", {phase, strobes}, {3'd2, 9'b0});
    exp_retired = exp_retired + 16'd1;
    @(negedge clk); #1;
    check("HLT halted", {phase, strobes, retired}, {3'd0, 9'b000000001, exp_retired});
    @(negedge clk); #1;
    check("HLT stays", {29'd0, phase}, 32'd0);
    start_run();
    do_instr("LD restart", 16'h0000, 1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of an outstanding data access.
    @(negedge clk); COMMAND = 16'h0000; mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("pre-reset MEM", {phase, mem_req}, {3'd4, 1'b1});
    #1; reset = 1'b1; #1;
    check("async reset", {phase, strobes, retired}, {3'd0, 9'b000000001, 16'h0000});
    exp_retired = 16'h0000;
    @(negedge clk); reset = 1'b0; #1;
    check("reset release HALT", {29'd0, phase}, 32'd0);

    // Wrap of the retired counter.
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_retired = 16'hFFFF;
    #1;
    check("preset", {16'd0, retired}, {16'd0, exp_retired});
    start_run();
    do_instr("LI wrap", 16'h8000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); run = 1'b0; #1;
    check("wrap", {phase, retired}, {3'd1, 16'h0000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port run, input, 1: start request, honoured only in HALT.
REQ-004 SHALL have port COMMAND, input, 16: current instruction-register contents.
REQ-005 SHALL have port mem_ack, input, 1: memory completion for the current mem_req.
REQ-006 SHALL have port branch_taken, input, 1: condition result for a conditional branch, sampled in WB.
REQ-007 SHALL have outputs ir_load, pc_inc, pc_load_en, mem_req, mem_we, mem_sel_data, reg_we, flag_we, halted, each 1 bit.
- mem_sel_data: 0 = PC address, 1 = data address.
REQ-008 SHALL have output phase, 3 bits: state encoding. SHALL have output retired, 16 bits: retired-instruction count.

Function
REQ-009 SHALL implement states HALT=0, IF=1, ID=2, EX=3, MEM=4, WB=5; codes 6 and 7 SHALL go to HALT on the next edge.
REQ-010 SHALL decode classes from COMMAND:
- LD = [15:14]==00; ST = 01
- LI = [15:11]==10000; B = 10100; BC = 10111
- ALU = [15:14]==11
- HLT = ALU with [7:4]==1111
- any other 10xxx pattern is NOP
REQ-011 HALT: halted=1; run=1 SHALL move to IF on the next edge; run=0 stays.
REQ-012 IF: mem_req=1, mem_sel_data=0; stay until mem_ack=1; in the ack cycle assert ir_load=1 and pc_inc=1 for exactly one cycle, then go to ID.
REQ-013 ID: one cycle. HLT SHALL go to HALT and increment retired; all others SHALL go to EX.
REQ-014 EX: one cycle. flag_we=1 iff ALU and [7:4]<=0110; then go to MEM.
REQ-015 MEM for LD/ST: mem_req=1, mem_sel_data=1, mem_we=1 iff ST; wait for mem_ack, then go to WB. Non-memory instructions SHALL spend one idle cycle in MEM with all strobes 0.
REQ-016 WB: one cycle, then go to IF; retired increments by 1.
- reg_we=1 iff LD, LI, or ALU with [7:4]<=1100
- pc_load_en=1 iff B, or BC with branch_taken=1
REQ-017 All strobes not listed for a state SHALL be 0 (Moore-style except the ir_load/pc_inc ack qualifier).
REQ-018 mem_ack while mem_req=0 SHALL be ignored; run outside HALT SHALL be ignored.
REQ-019 retired SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-020 Minimum latency per instruction, zero wait states: 5 cycles (IF to WB inclusive).

Reset
REQ-021 reset=1 SHALL immediately force state HALT, halted=1, retired=0, and all other outputs 0, regardless of the current phase or an outstanding mem_req.
REQ-022 After reset deassertion, the block SHALL stay in HALT until run=1.

Configuration
REQ-023 With macro PHASE_SKIP_EN defined, EX SHALL go directly to WB for non-LD/ST instructions (minimum 4 cycles). Without it, REQ-015's idle MEM cycle applies.

Structure
REQ-024 State codes, class-decode constants and the ALU op-field thresholds (0110, 1100, 1111) SHALL live in shared package simple_pkg.
REQ-025 A combinational sub-module instr_class SHALL map COMMAND to class flags; the FSM and counter stay in phase_sequencer.

Verification
REQ-026 Reset, then run pulse; ack at the first IF cycle with COMMAND=0xC000 (ADD) -> phases 1,2,3,4,5,1; flag_we in EX; reg_we in WB; retired=1.
REQ-027 COMMAND=0x4000 (ST), mem_ack delayed 3 cycles in MEM -> mem_req=1, mem_we=1, mem_sel_data=1 held for 4 cycles; reg_we=0 in WB.
REQ-028 COMMAND=0xB800 (BC): branch_taken=1 -> pc_load_en=1 in WB; repeat with branch_taken=0 -> pc_load_en=0.
REQ-029 COMMAND=0xC0F0 (HLT) -> HALT after ID, halted=1, retired increments; run=1 restarts at IF.
REQ-030 reset asserted mid-MEM with mem_req=1 -> same-cycle HALT, mem_req=0, retired=0; retired preset near 0xFFFF wraps to 0x0000 after one WB.
REQ-031 Under PHASE_SKIP_EN, COMMAND=0x8000 (LI) -> phases 1,2,3,5; reg_we=1.
